// File: rtl/vx_mem_traffic_gen_if.sv
// Vortex memory request/response bus between the traffic generator (master)
// and a memory responder (slave).
interface vx_mem_traffic_gen_if #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 512,
    parameter int TAG_WIDTH  = 56
);
    logic                      mem_req_valid;
    logic                      mem_req_rw;
    logic [DATA_WIDTH/8-1:0]   mem_req_byteen;
    logic [ADDR_WIDTH-1:0]     mem_req_addr;
    logic [DATA_WIDTH-1:0]     mem_req_data;
    logic [TAG_WIDTH-1:0]      mem_req_tag;
    logic                      mem_req_ready;
    logic                      mem_rsp_valid;
    logic [DATA_WIDTH-1:0]     mem_rsp_data;
    logic [TAG_WIDTH-1:0]      mem_rsp_tag;
    logic                      mem_rsp_ready;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
               mem_req_data, mem_req_tag, mem_rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
               mem_req_data, mem_req_tag, mem_rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
    );
endinterface

// File: rtl/vx_mem_traffic_gen.sv
// Memory traffic generator: writes a seeded pattern to a line range, reads it back
// with bounded outstanding reads and checks every response. Optional watchdog: VX_TRAFFIC_GEN_TIMEOUT_EN.
module vx_mem_traffic_gen #(
    parameter int          ADDR_WIDTH      = 26,
    parameter int          DATA_WIDTH      = 512,
    parameter int          TAG_WIDTH       = 56,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] SEED            = 32'hA5A5_0000,
    parameter int          TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [15:0]           num_lines,
    vx_mem_traffic_gen_if.master  mem,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count
);
    localparam int WORDS = DATA_WIDTH / 32;

    if ((DATA_WIDTH % 32) != 0 || TAG_WIDTH < 16 || MAX_OUTSTANDING < 1 ||
        MAX_OUTSTANDING > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("vx_mem_traffic_gen: illegal parameter combination");
    end

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_num;
    logic [15:0]           r_idx;
    logic [7:0]            r_out;
    logic [15:0]           r_err;
    logic                  r_req_valid;
    logic                  r_req_rw;
    logic [DATA_WIDTH-1:0] r_req_data;
    logic [TAG_WIDTH-1:0]  r_req_tag;
    logic                  r_rsp_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;

    function automatic logic [DATA_WIDTH-1:0] f_pattern(input logic [15:0] idx);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        for (int w = 0; w < WORDS; w++) begin
            v[w*32 +: 32] = SEED ^ {idx, 16'(w)};
        end
        return v;
    endfunction

    function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic        w_active;
    logic        w_fire;
    logic        w_rd_fire;
    logic        w_rsp;
    logic        w_rsp_err;
    logic        w_rsp_dec;
    logic [7:0]  w_out_next;
    logic [15:0] w_err_next;
    logic        w_can_issue;
    logic        w_last;
    logic        w_wd_hit;

    assign w_active    = (r_state == S_WRITE) || (r_state == S_READ) || (r_state == S_DRAIN);
    assign w_fire      = r_req_valid & mem.mem_req_ready;
    assign w_rd_fire   = w_fire & ~r_req_rw;
    assign w_rsp       = mem.mem_rsp_valid & w_active;
    // A stray response (nothing outstanding) is flagged but never underflows the counter.
    assign w_rsp_err   = w_rsp & ((r_out == 8'd0) ||
                                  (mem.mem_rsp_tag >= TAG_WIDTH'(r_num)) ||
                                  (mem.mem_rsp_data != f_pattern(mem.mem_rsp_tag[15:0])));
    assign w_rsp_dec   = w_rsp & (r_out != 8'd0);
    assign w_out_next  = r_out + {7'd0, w_rd_fire} - {7'd0, w_rsp_dec};
    assign w_err_next  = w_rsp_err ? f_sat_inc(r_err) : r_err;
    assign w_can_issue = w_out_next < 8'(MAX_OUTSTANDING);
    assign w_last      = (r_idx == r_num - 16'd1);

`ifdef VX_TRAFFIC_GEN_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] r_wd;
    logic            w_wd_count;

    assign w_wd_count = ((r_state == S_READ) || (r_state == S_DRAIN)) &&
                        (r_out != 8'd0) && !mem.mem_rsp_valid;
    assign w_wd_hit   = w_wd_count && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd <= '0;
        end else begin
            r_wd <= w_wd_count ? r_wd + 1'b1 : '0;
        end
    end
`else
    assign w_wd_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_addr      <= '0;
            r_num       <= '0;
            r_idx       <= '0;
            r_out       <= '0;
            r_err       <= '0;
            r_req_valid <= 1'b0;
            r_req_rw    <= 1'b0;
            r_req_data  <= '0;
            r_req_tag   <= '0;
            r_rsp_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_rsp_ready <= 1'b1;
            r_out       <= w_out_next;
            r_err       <= w_err_next;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_base <= base_addr;
                        r_addr <= base_addr;
                        r_num  <= num_lines;
                        r_idx  <= '0;
                        r_out  <= '0;
                        r_err  <= '0;
                        if (num_lines == 16'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state     <= S_WRITE;
                            r_busy      <= 1'b1;
                            r_done      <= 1'b0;
                            r_pass      <= 1'b0;
                            r_req_valid <= 1'b1;
                            r_req_rw    <= 1'b1;
                            r_req_data  <= f_pattern(16'd0);
                            r_req_tag   <= '0;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_fire) begin
                        if (w_last) begin
                            r_state     <= S_READ;
                            r_req_valid <= 1'b0;
                            r_req_rw    <= 1'b0;
                            r_idx       <= '0;
                            r_addr      <= r_base;
                            r_req_tag   <= '0;
                        end else begin
                            r_idx      <= r_idx + 16'd1;
                            r_addr     <= r_addr + 1'b1;
                            r_req_data <= f_pattern(r_idx + 16'd1);
                        end
                    end
                end
                S_READ: begin
                    if (w_fire) begin
                        if (w_last) begin
                            r_state     <= S_DRAIN;
                            r_req_valid <= 1'b0;
                        end else begin
                            r_idx       <= r_idx + 16'd1;
                            r_addr      <= r_addr + 1'b1;
                            r_req_tag   <= TAG_WIDTH'(r_idx + 16'd1);
                            r_req_valid <= w_can_issue;
                        end
                    end else if (!r_req_valid) begin
                        r_req_valid <= w_can_issue;
                    end
                end
                S_DRAIN: begin
                    if (w_out_next == 8'd0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 16'd0);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // Watchdog abort: reads still in flight are abandoned and late returns ignored.
            if (w_wd_hit) begin
                r_state     <= S_DONE;
                r_req_valid <= 1'b0;
                r_out       <= '0;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_pass      <= 1'b0;
            end
        end
    end

    assign mem.mem_req_valid  = r_req_valid;
    assign mem.mem_req_rw     = r_req_rw;
    assign mem.mem_req_byteen = '1;
    assign mem.mem_req_addr   = r_addr;
    assign mem.mem_req_data   = r_req_data;
    assign mem.mem_req_tag    = r_req_tag;
    assign mem.mem_rsp_ready  = r_rsp_ready;
    assign busy               = r_busy;
    assign done               = r_done;
    assign pass               = r_pass;
    assign err_count          = r_err;
endmodule

// File: tb/tb_vx_mem_traffic_gen.sv
// Directed bench for vx_mem_traffic_gen: a behavioural memory responder with
// ideal, stalling, reordering, corrupting and dropping modes.
module tb_vx_mem_traffic_gen;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [25:0] base_addr = '0;
    logic [15:0] num_lines = '0;
    logic        busy, done, pass;
    logic [15:0] err_count;

    vx_mem_traffic_gen_if #(.ADDR_WIDTH(26), .DATA_WIDTH(512), .TAG_WIDTH(56)) mem_if ();

    vx_mem_traffic_gen dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_lines (num_lines),
        .mem       (mem_if),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct { int tag; logic [511:0] data; int due; } rsp_t;

    rsp_t        outq[$];
    rsp_t        hold[$];
    logic [511:0] mem_model [logic [25:0]];
    logic [25:0] wr_addr_q[$];
    logic [511:0] wr_data_q[$];
    int mode = 0;          // 0 ideal, 1 stall/latency, 2 reverse groups, 3 drop one
    int corrupt_tag = -1;
    int drop_tag = -1;
    bit inject9 = 1'b0;
    int cur_num = 0;
    int cyc = 0;
    int wr_fires, rd_fires, first_wr, last_wr, inflight, max_inflight, viol, last_rsp_cyc;

    logic         prev_valid, prev_ready, prev_rw, prev_fire_wr;
    logic [25:0]  prev_addr;
    logic [511:0] prev_data;
    logic [55:0]  prev_tag;

    task automatic clear_stats();
        outq.delete();
        hold.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_fires = 0; rd_fires = 0; first_wr = 0; last_wr = 0;
        inflight = 0; max_inflight = 0; viol = 0; last_rsp_cyc = 0;
    endtask

    // Responder and protocol monitor; everything happens on the falling edge.
    initial begin
        rsp_t r;
        logic fire;
        clear_stats();
        prev_valid = 0; prev_ready = 0; prev_rw = 0; prev_fire_wr = 0;
        prev_addr = '0; prev_data = '0; prev_tag = '0;
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b0;
        mem_if.mem_rsp_data  = '0;
        mem_if.mem_rsp_tag   = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                outq.delete();
                hold.delete();
                inflight = 0;
                mem_if.mem_req_ready = 1'b0;
                mem_if.mem_rsp_valid = 1'b0;
                prev_valid = 0;
                prev_fire_wr = 0;
            end else begin
                if (prev_valid && !prev_ready &&
                    (!mem_if.mem_req_valid || mem_if.mem_req_addr !== prev_addr ||
                     mem_if.mem_req_data !== prev_data || mem_if.mem_req_tag !== prev_tag ||
                     mem_if.mem_req_rw !== prev_rw))
                    viol++;
                if (prev_fire_wr && mem_if.mem_req_valid && !mem_if.mem_req_rw)
                    viol++;
                mem_if.mem_rsp_valid = 1'b0;
                if (outq.size() > 0 && outq[0].due <= cyc) begin
                    r = outq.pop_front();
                    mem_if.mem_rsp_valid = 1'b1;
                    mem_if.mem_rsp_data  = r.data;
                    mem_if.mem_rsp_tag   = 56'(r.tag);
                    if (r.tag < cur_num) inflight--;
                    last_rsp_cyc = cyc;
                end
                mem_if.mem_req_ready = (mode == 1) ? ((cyc % 4) == 0) : 1'b1;
                fire = mem_if.mem_req_valid && mem_if.mem_req_ready;
                prev_fire_wr = fire && mem_if.mem_req_rw;
                if (fire && mem_if.mem_req_rw) begin
                    mem_model[mem_if.mem_req_addr] = mem_if.mem_req_data;
                    wr_fires++;
                    if (wr_fires == 1) first_wr = cyc;
                    last_wr = cyc;
                    wr_addr_q.push_back(mem_if.mem_req_addr);
                    wr_data_q.push_back(mem_if.mem_req_data);
                end else if (fire) begin
                    rd_fires++;
                    inflight++;
                    if (inflight > max_inflight) max_inflight = inflight;
                    r.tag  = int'(mem_if.mem_req_tag[15:0]);
                    r.data = mem_model.exists(mem_if.mem_req_addr) ? mem_model[mem_if.mem_req_addr] : '0;
                    if (r.tag == corrupt_tag) r.data[0] = ~r.data[0];
                    r.due  = cyc + ((mode == 1) ? 20 : 1);
                    if (mode == 3 && r.tag == drop_tag) begin
                        // lost in the memory system
                    end else if (mode == 2) begin
                        hold.push_back(r);
                        if (hold.size() == 4 || rd_fires == cur_num) begin
                            if (inject9 && rd_fires == cur_num)
                                outq.push_back('{tag: 9, data: '0, due: cyc + 1});
                            while (hold.size() > 0) begin
                                r = hold.pop_back();
                                r.due = cyc + 1;
                                outq.push_back(r);
                            end
                        end
                    end else begin
                        outq.push_back(r);
                    end
                end
                prev_valid = mem_if.mem_req_valid;
                prev_ready = mem_if.mem_req_ready;
                prev_rw    = mem_if.mem_req_rw;
                prev_addr  = mem_if.mem_req_addr;
                prev_data  = mem_if.mem_req_data;
                prev_tag   = mem_if.mem_req_tag;
            end
        end
    end

    task automatic launch(input logic [25:0] b, input int n);
        @(posedge clk);
        clear_stats();
        cur_num = n;
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        num_lines = 16'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int waited;
        // Reset values
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid",  64'(mem_if.mem_req_valid), 64'd0);
        chk("rst_byteen", 64'(mem_if.mem_req_byteen), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_addr",   64'(mem_if.mem_req_addr), 64'd0);
        chk("rst_rspr",   64'(mem_if.mem_rsp_ready), 64'd0);
        chk("rst_status", 64'({busy, done, pass, err_count}), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_rspr", 64'(mem_if.mem_rsp_ready), 64'd1);

        // Ideal memory, base 0, 8 lines
        mode = 0;
        launch(26'd0, 8);
        chk("ideal_first_valid", 64'({mem_if.mem_req_valid, mem_if.mem_req_rw, busy}), 64'b111);
        wait_done("ideal_done", 200);
        chk("ideal_status", 64'({pass, err_count}), {47'd0, 1'b1, 16'd0});
        chk("ideal_counts", 64'({wr_fires[15:0], rd_fires[15:0]}), {32'd0, 16'd8, 16'd8});
        chk("ideal_b2b", 64'(last_wr - first_wr), 64'd7);
        chk("ideal_w3_addr", 64'(wr_addr_q[3]), 64'd3);
        chk("ideal_w3_word0", 64'(wr_data_q[3][31:0]), 64'hA5A6_0000);
        chk("ideal_w7_word15", 64'(wr_data_q[7][511:480]), 64'hA5A2_000F);
        chk("ideal_proto", 64'(viol), 64'd0);

        // Stalling responder, 20-cycle latency, 16 lines, start while busy ignored
        mode = 1;
        launch(26'd100, 16);
        repeat (10) @(negedge clk);
        start = 1'b1; base_addr = 26'd0; num_lines = 16'd3;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_ignored", 64'({busy, done}), 64'b10);
        wait_done("stall_done", 3000);
        chk("stall_status", 64'({pass, err_count}), {47'd0, 1'b1, 16'd0});
        chk("stall_counts", 64'({wr_fires[15:0], rd_fires[15:0]}), {32'd0, 16'd16, 16'd16});
        chk("stall_max_out_le4", 64'(max_inflight <= 4), 64'd1);
        chk("stall_max_out_hit4", 64'(max_inflight), 64'd4);
        chk("stall_base", 64'(wr_addr_q[0]), 64'd100);
        chk("stall_proto", 64'(viol), 64'd0);

        // Corrupted line 5
        mode = 0; corrupt_tag = 5;
        launch(26'd0, 8);
        wait_done("corrupt_done", 200);
        chk("corrupt_status", 64'({pass, err_count}), {47'd0, 1'b0, 16'd1});
        corrupt_tag = -1;

        // Reversed responses only
        mode = 2; inject9 = 1'b0;
        launch(26'd40, 8);
        wait_done("rev_done", 300);
        chk("rev_status", 64'({pass, err_count}), {47'd0, 1'b1, 16'd0});

        // Reversed responses plus an illegal tag 9
        inject9 = 1'b1;
        launch(26'd40, 8);
        wait_done("rev9_done", 300);
        chk("rev9_status", 64'({pass, err_count}), {47'd0, 1'b0, 16'd1});
        inject9 = 1'b0;
        repeat (3) @(negedge clk);

        // Zero lines: done on the cycle after start, err cleared, no requests
        mode = 0;
        launch(26'd7, 0);
        chk("zero_status", 64'({done, pass, busy, err_count}), {45'd0, 3'b110, 16'd0});
        chk("zero_valid", 64'(mem_if.mem_req_valid), 64'd0);
        repeat (4) @(negedge clk);
        chk("zero_reqs", 64'(wr_fires + rd_fires), 64'd0);

        // Address wrap
        launch(26'h3FF_FFFF, 2);
        wait_done("wrap_done", 100);
        chk("wrap_addr0", 64'(wr_addr_q[0]), 64'h3FF_FFFF);
        chk("wrap_addr1", 64'(wr_addr_q[1]), 64'd0);
        chk("wrap_status", 64'({pass, err_count}), {47'd0, 1'b1, 16'd0});

        // Asynchronous reset in the middle of READ
        mode = 1;
        launch(26'd200, 16);
        waited = 0;
        while (rd_fires < 2 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        chk("midrd_reached", 64'(rd_fires >= 2), 64'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrd_rst_req", 64'({mem_if.mem_req_valid, mem_if.mem_req_rw, mem_if.mem_rsp_ready}), 64'd0);
        chk("midrd_rst_addr", 64'(mem_if.mem_req_addr), 64'd0);
        chk("midrd_rst_byteen", 64'(mem_if.mem_req_byteen), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("midrd_rst_status", 64'({busy, done, pass}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mode = 0;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", 64'({busy, done, mem_if.mem_req_valid}), 64'd0);
        launch(26'd300, 4);
        wait_done("post_rst_done", 200);
        chk("post_rst_status", 64'({pass, err_count}), {47'd0, 1'b1, 16'd0});

`ifdef VX_TRAFFIC_GEN_TIMEOUT_EN
        // One read lost: the watchdog closes the run
        mode = 3; drop_tag = 2;
        launch(26'd0, 8);
        wait_done("wd_done", 3000);
        chk("wd_status", 64'({pass, err_count}), {47'd0, 1'b0, 16'd0});
        chk("wd_latency", 64'((cyc - last_rsp_cyc) >= 1023 && (cyc - last_rsp_cyc) <= 1025), 64'd1);
        drop_tag = -1;
        mode = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
